// File: rtl/demod_decim_filter_if.sv
// Sample-in / audio-out bundle between the conjugate multiplier, the
// boxcar decimator and the audio output path.
interface demod_decim_filter_if #(
  parameter int WIDTH = 16
) ();
  logic                    start_i;
  logic signed [WIDTH-1:0] demod_i;
  logic signed [WIDTH-1:0] audio_o;
  logic                    valid_o;

  modport master (output start_i, output demod_i, input  audio_o, input  valid_o);
  modport slave  (input  start_i, input  demod_i, output audio_o, output valid_o);
endinterface

// File: rtl/demod_decim_filter.sv
// Post-demodulation 2^LOG2_LEN-tap boxcar low-pass with decimation by DECIM.
// One sample per clock; the output is registered on the accepting edge.
module demod_decim_filter #(
  parameter int WIDTH    = 16,
  parameter int LOG2_LEN = 3,
  parameter int DECIM    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  demod_decim_filter_if.slave  bus
);
  localparam int N  = 1 << LOG2_LEN;
  localparam int SW = WIDTH + LOG2_LEN;
  localparam int FW = LOG2_LEN + 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [WIDTH-1:0]        mem_q [N];
  logic [LOG2_LEN-1:0]     wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic                    primed_q, primed_d;
  logic [DW-1:0]           decim_q, decim_d;
  logic signed [SW-1:0]    sum_q, sum_d;
  logic signed [WIDTH-1:0] audio_q, audio_d;
  logic                    valid_q, valid_d;
  logic [WIDTH-1:0]        oldest;
  logic                    accept, fire;

  assign accept      = bus.start_i;
  assign bus.audio_o = audio_q;
  assign bus.valid_o = valid_q;

  always_comb begin
    // Until the window is full the slot being overwritten holds stale data.
    oldest   = primed_q ? mem_q[wr_ptr_q] : '0;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    primed_d = primed_q;
    decim_d  = decim_q;
    sum_d    = sum_q;
    audio_d  = audio_q;
    valid_d  = 1'b0;
    fire     = 1'b0;
    if (accept) begin
      sum_d    = sum_q + {{LOG2_LEN{bus.demod_i[WIDTH-1]}}, bus.demod_i}
                       - {{LOG2_LEN{oldest[WIDTH-1]}}, oldest};
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (!primed_q) begin
        fill_d = fill_q + 1'b1;
        if (fill_q == FW'(N - 1)) begin
          primed_d = 1'b1;
          decim_d  = '0;
          fire     = 1'b1;
        end
      end else if (decim_q == DW'(DECIM - 1)) begin
        decim_d = '0;
        fire    = 1'b1;
      end else begin
        decim_d = decim_q + 1'b1;
      end
      if (fire) begin
        // Dropping the low bits of the two's-complement sum is a floor divide.
        audio_d = sum_d[SW-1:LOG2_LEN];
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
      decim_q  <= '0;
      sum_q    <= '0;
      audio_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      primed_q <= primed_d;
      decim_q  <= decim_d;
      sum_q    <= sum_d;
      audio_q  <= audio_d;
      valid_q  <= valid_d;
    end
  end

  // Delay line has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (accept && !rst) mem_q[wr_ptr_q] <= bus.demod_i;
  end
endmodule
